// File: rtl/seg_scan_display.sv
// seg_scan_display: captures a 32-bit write value, converts it to four BCD
// digits with a sequential double-dabble engine (14 iterations), and
// time-multiplexes the digits onto active-low segment lines with active-low
// one-hot digit enables. Values above 9999 display as four dashes.
//
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN
//   defined   -> zero digits above the most significant non-zero digit are
//                blanked (units digit and dashes are never blanked)
//   undefined -> all four digits are always shown
//
// Handshake: load is a fire-and-forget strobe with no ready. It is accepted on
// every rising edge where it is high, regardless of busy. A load while busy
// restarts conversion (latest wins). busy is status only.
module seg_scan_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] value,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        busy
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    // conversion state
    logic [13:0] shift_q;
    logic [15:0] bcd_q;
    logic [3:0]  iter_q;
    logic        ovf_q;
    logic [15:0] disp_q;

    // scan state
    logic [CW-1:0] scan_cnt_q;
    logic [1:0]    idx_q;

    // next double-dabble step
    logic [15:0] bcd_adj;
    logic [15:0] bcd_next;
    logic [13:0] shift_next;

    // digit selection
    logic [3:0] digit_code;
    logic       digit_blank;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hF:    s = 7'b0111111;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Add-3 correction on every nibble >= 5, then shift the next source bit in.
    // Nibble sums wrap at 4 bits so nothing carries out of the BCD field.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_next   = {bcd_adj[14:0], shift_q[13]};
        shift_next = {shift_q[12:0], 1'b0};
    end

    // Pick the digit currently being scanned and decide whether it is a
    // blanked leading zero.
    always_comb begin
        logic [3:0] upper_zero;
        digit_code  = disp_q[4*idx_q +: 4];
        upper_zero  = 4'b0000;
        digit_blank = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        upper_zero[3] = (disp_q[15:12] == 4'h0);
        upper_zero[2] = upper_zero[3] && (disp_q[11:8] == 4'h0);
        upper_zero[1] = upper_zero[2] && (disp_q[7:4] == 4'h0);
        upper_zero[0] = 1'b0;
        digit_blank   = upper_zero[idx_q];
`else
        digit_blank = upper_zero[idx_q];
`endif
    end

    // Capture / convert / commit. A commit and a new load may share an edge:
    // the display updates and the new capture overrides the busy clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            ovf_q   <= 1'b0;
            disp_q  <= '0;
            busy    <= 1'b0;
        end else begin
            if (busy) begin
                shift_q <= shift_next;
                bcd_q   <= bcd_next;
                iter_q  <= iter_q + 4'd1;
                if (iter_q == 4'd13) begin
                    disp_q <= ovf_q ? 16'hFFFF : bcd_next;
                    busy   <= 1'b0;
                end
            end
            if (load) begin
                shift_q <= value[13:0];
                bcd_q   <= '0;
                iter_q  <= '0;
                ovf_q   <= (value > 32'd9999);
                busy    <= 1'b1;
            end
        end
    end

    // Scan: an and seg both come from the same index so they change together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
            an         <= 4'hF;
            seg        <= 7'h7F;
        end else begin
            an  <= ~(4'b0001 << idx_q);
            seg <= digit_blank ? 7'b1111111 : decode(digit_code);
            if (scan_cnt_q == SCAN_LAST) begin
                scan_cnt_q <= '0;
                idx_q      <= idx_q + 2'd1;
            end else begin
                scan_cnt_q <= scan_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Testbench for seg_scan_display. Two instances share clock, reset and the
// load/value inputs: one scans with SCAN_DIV=3, the other with SCAN_DIV=2.
// The reference model works in decimal: it tracks the displayed integer,
// the pending value and a 14-edge countdown, and derives the scanned digit
// from the number of edges since reset release.
module tb_seg_scan_display;

  localparam int SD_A = 3;
  localparam int SD_B = 2;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic        load    = 1'b0;
  logic [31:0] value   = '0;

  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;
  logic       busy_a, busy_b;

  int n_assert = 0;
  int n_fail   = 0;

  // model state
  longint     m_disp;
  longint     m_val;
  bit         m_busy;
  int         m_rem;
  int         m_ticks;
  logic [6:0] m_seg [2];
  logic [3:0] m_an  [2];

  logic [6:0] seen_seg [4];

  always #5 clock = ~clock;

  seg_scan_display #(.SCAN_DIV(SD_A)) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (load),
    .value   (value),
    .seg     (seg_a),
    .an      (an_a),
    .busy    (busy_a)
  );

  seg_scan_display #(.SCAN_DIV(SD_B)) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (load),
    .value   (value),
    .seg     (seg_b),
    .an      (an_b),
    .busy    (busy_b)
  );

  function automatic logic [6:0] seg_code(input int code);
    case (code)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      15:      return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic longint pow10(input int n);
    longint p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  // segments expected for digit position i of displayed integer v
  function automatic logic [6:0] expect_digit(input longint v, input int i);
    if (v > 9999) return seg_code(15);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (i > 0 && v < pow10(i)) return 7'b1111111;
`endif
    return seg_code(int'((v / pow10(i)) % 10));
  endfunction

  task automatic model_reset();
    m_disp  = 0;
    m_val   = 0;
    m_busy  = 1'b0;
    m_rem   = 0;
    m_ticks = 0;
    for (int j = 0; j < 2; j++) begin
      m_seg[j] = 7'h7F;
      m_an[j]  = 4'hF;
    end
  endtask

  task automatic model_edge();
    int sd;
    int idx;
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int j = 0; j < 2; j++) begin
      sd       = (j == 0) ? SD_A : SD_B;
      idx      = (m_ticks / sd) % 4;
      m_an[j]  = ~(4'b0001 << idx);
      m_seg[j] = expect_digit(m_disp, idx);
    end
    m_ticks++;
    if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        m_disp = m_val;
        m_busy = 1'b0;
      end
    end
    if (load) begin
      m_busy = 1'b1;
      m_rem  = 14;
      m_val  = longint'(value);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("an_a",   {28'h0, an_a},   {28'h0, m_an[0]});
    check("seg_a",  {25'h0, seg_a},  {25'h0, m_seg[0]});
    check("busy_a", {31'h0, busy_a}, {31'h0, m_busy});
    check("an_b",   {28'h0, an_b},   {28'h0, m_an[1]});
    check("seg_b",  {25'h0, seg_b},  {25'h0, m_seg[1]});
    check("busy_b", {31'h0, busy_b}, {31'h0, m_busy});
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // record the segments shown for each digit over one full frame of dut_a
  task automatic capture_frame();
    for (int i = 0; i < 4; i++) seen_seg[i] = 7'hxx;
    for (int k = 0; k < 4 * SD_A + 1; k++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (an_a == ~(4'b0001 << i)) seen_seg[i] = seg_a;
      end
    end
  endtask

  // count edges (including the load edge) on which busy_a reads high
  task automatic load_and_count(input logic [31:0] v, output int cnt);
    cnt   = 0;
    load  = 1'b1;
    value = v;
    tick();
    load = 1'b0;
    if (busy_a) cnt++;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (busy_a) cnt++;
    end
  endtask

  initial begin
    int cnt;
    logic [6:0] exp_lo;
    model_reset();

    // asynchronous reset assert
    #1 reset_n = 1'b0;
    #1 check_all();
    ticks(2);
    reset_n = 1'b0;
    reset_n = 1'b1;

    // first edge after release
    tick();
    check("first_an",  {28'h0, an_a},  32'h0000_000E);
    check("first_seg", {25'h0, seg_a}, 32'h0000_0040);

    // idle scanning, two full frames
    ticks(8 * SD_A);

    // 1234: 14 busy edges, then digit patterns
    load_and_count(32'd1234, cnt);
    check("busy_len_1234", cnt, 32'd14);
    capture_frame();
    check("d0_1234", {25'h0, seen_seg[0]}, {25'h0, 7'b0011001});
    check("d1_1234", {25'h0, seen_seg[1]}, {25'h0, 7'b0110000});
    check("d2_1234", {25'h0, seen_seg[2]}, {25'h0, 7'b0100100});
    check("d3_1234", {25'h0, seen_seg[3]}, {25'h0, 7'b1111001});

    // overflow -> dashes
    load_and_count(32'd10000, cnt);
    check("busy_len_10000", cnt, 32'd14);
    capture_frame();
    for (int i = 0; i < 4; i++)
      check("dash_10000", {25'h0, seen_seg[i]}, {25'h0, 7'b0111111});

    // 9999 then restart with 5 on busy cycle 6
    load  = 1'b1;
    value = 32'd9999;
    tick();
    load = 1'b0;
    ticks(5);
    load_and_count(32'd5, cnt);
    check("busy_len_restart", cnt, 32'd14);
    capture_frame();
`ifdef SEG_LEADING_ZERO_BLANK_EN
    exp_lo = 7'b1111111;
`else
    exp_lo = 7'b1000000;
`endif
    check("d0_5", {25'h0, seen_seg[0]}, {25'h0, 7'b0010010});
    for (int i = 1; i < 4; i++)
      check("dhi_5", {25'h0, seen_seg[i]}, {25'h0, exp_lo});

    // 8888 committed, then reset during conversion of 0
    load_and_count(32'd8888, cnt);
    load  = 1'b1;
    value = 32'd0;
    tick();
    load = 1'b0;
    ticks(6);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_seg",  {25'h0, seg_a},  32'h0000_007F);
    check("rst_an",   {28'h0, an_a},   32'h0000_000F);
    check("rst_busy", {31'h0, busy_a}, 32'h0000_0000);
    check_all();
    ticks(2);
    reset_n = 1'b1;
    capture_frame();
    check("d0_after_rst", {25'h0, seen_seg[0]}, {25'h0, 7'b1000000});
    for (int i = 1; i < 4; i++)
      check("dhi_after_rst", {25'h0, seen_seg[i]}, {25'h0, exp_lo});

    // load on the commit edge: commit completes, new conversion follows
    load  = 1'b1;
    value = 32'd42;
    tick();
    load = 1'b0;
    ticks(13);
    load  = 1'b1;
    value = 32'd77;
    tick();
    load = 1'b0;
    check("busy_after_commit_load", {31'h0, busy_a}, 32'h1);
    ticks(20);

    // randomized loads, gaps, held loads and occasional resets
    for (int r = 0; r < 80; r++) begin
      case ($urandom_range(0, 9))
        0:       value = $urandom();
        1:       value = $urandom_range(9990, 10010);
        default: value = $urandom_range(0, 9999);
      endcase
      load = 1'b1;
      ticks($urandom_range(1, 2));
      load = 1'b0;
      if ($urandom_range(0, 11) == 0) begin
        ticks($urandom_range(0, 13));
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        ticks($urandom_range(1, 3));
        reset_n = 1'b1;
      end
      ticks($urandom_range(0, 24));
    end
    ticks(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
